// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: one column mixer reused over four cycles per 128-bit state.
// Define MIX_COLUMNS_INV_EN to add the inv port and InvMixColumns support.
module mix_columns_seq (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
`ifdef MIX_COLUMNS_INV_EN
    ,
    input  logic         inv
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] work_q, work_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;

    logic [31:0]  col_in;
    logic [31:0]  col_out;
    logic [31:0]  col_fwd;
    logic [7:0]   b  [4];
    logic [7:0]   x2 [4];
    logic [7:0]   x3 [4];

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // Column cnt_q of the working register feeds the shared mixer.
    always_comb begin
        col_in = work_q[31:0];
        case (cnt_q)
            2'd0: col_in = work_q[31:0];
            2'd1: col_in = work_q[63:32];
            2'd2: col_in = work_q[95:64];
            2'd3: col_in = work_q[127:96];
            default: col_in = work_q[31:0];
        endcase
    end

    // Row r of the forward matrix is {2,3,1,1} rotated right by r.
    for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
        assign b[gi]  = col_in[31-8*gi -: 8];
        assign x2[gi] = xtime(b[gi]);
        assign x3[gi] = x2[gi] ^ b[gi];
        assign col_fwd[31-8*gi -: 8] = x2[gi] ^ x3[(gi+1)%4] ^ b[(gi+2)%4] ^ b[(gi+3)%4];
    end

`ifdef MIX_COLUMNS_INV_EN
    logic         inv_q, inv_d;
    logic [31:0]  col_inv;
    logic [7:0]   x4  [4];
    logic [7:0]   x8  [4];
    logic [7:0]   m09 [4];
    logic [7:0]   m0b [4];
    logic [7:0]   m0d [4];
    logic [7:0]   m0e [4];

    // Inverse coefficients built from the x2/x4/x8 doubling chain.
    for (genvar gi = 0; gi < 4; gi++) begin : g_inv
        assign x4[gi]  = xtime(x2[gi]);
        assign x8[gi]  = xtime(x4[gi]);
        assign m09[gi] = x8[gi] ^ b[gi];
        assign m0b[gi] = x8[gi] ^ x2[gi] ^ b[gi];
        assign m0d[gi] = x8[gi] ^ x4[gi] ^ b[gi];
        assign m0e[gi] = x8[gi] ^ x4[gi] ^ x2[gi];
        assign col_inv[31-8*gi -: 8] = m0e[gi] ^ m0b[(gi+1)%4] ^ m0d[(gi+2)%4] ^ m09[(gi+3)%4];
    end

    assign col_out = inv_q ? col_inv : col_fwd;
`else
    assign col_out = col_fwd;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
`ifdef MIX_COLUMNS_INV_EN
        inv_d   = inv_q;
`endif
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_d  = data_in;
                        cnt_d   = 2'd0;
                        state_d = ST_COMPUTE;
`ifdef MIX_COLUMNS_INV_EN
                        inv_d   = inv;
`endif
                    end
                end
                ST_COMPUTE: begin
                    case (cnt_q)
                        2'd0: work_d[31:0]   = col_out;
                        2'd1: work_d[63:32]  = col_out;
                        2'd2: work_d[95:64]  = col_out;
                        2'd3: work_d[127:96] = col_out;
                        default: work_d[31:0] = col_out;
                    endcase
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    // Handshake flags are registered from the next-state decode.
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_COMPUTE) || (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef MIX_COLUMNS_INV_EN
            inv_q       <= inv_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign data_out  = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq against a matrix-product GF(2^8) reference model.
// Inverse scenarios are compiled in when MIX_COLUMNS_INV_EN is defined.
module tb_mix_columns_seq;

    logic         clk;
    logic         n_rst;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;
    bit           inv_mode;

    int checks;
    int fails;

`ifdef MIX_COLUMNS_INV_EN
    logic inv;
    assign inv = inv_mode;
`endif

    mix_columns_seq dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
`ifdef MIX_COLUMNS_INV_EN
        ,
        .inv       (inv)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Generic shift-and-add GF(2^8) product modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // Each output column is the circulant matrix times the input column.
    function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inverse);
        logic [7:0]   row0 [4];
        logic [7:0]   col  [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inverse) row0 = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else         row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) col[k] = s[32*c+31-8*k -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(col[k], row0[(k - rr + 4) % 4]);
                r[32*c+31-8*rr -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called at #1 after an edge while idle; returns #1 after the acceptance edge.
    task automatic start_op(input logic [127:0] din);
        in_valid = 1'b1;
        data_in  = din;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in  = rand128();
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || data_out !== 128'h0) begin
            fails++;
            $display("FAIL reset_values: got rdy=%b vld=%b busy=%b dout=%h, required 1 0 0 0",
                     in_ready, out_valid, busy, data_out);
        end
        n_rst = 1'b1;
    endtask

    task automatic test_first_accept();
        int           lat;
        logic [127:0] exp;
        inv_mode = 1'b0;
        exp = {4{32'h8e4da1bc}};
        start_op({4{32'hdb135345}});
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL first_accept: got busy=%b rdy=%b, required busy=1 rdy=0", busy, in_ready);
        end
        wait_done(lat);
        checks++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL db135345_latency: got %0d edges, required 4", lat);
        end
        checks++;
        if (data_out !== exp) begin
            fails++;
            $display("FAIL db135345_result: got %h, required %h", data_out, exp);
        end
        $display("txn db135345 x4 -> %h latency %0d", data_out, lat);
        finish_op();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL handshake_to_idle: got rdy=%b vld=%b busy=%b, required 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_mixed_columns();
        int           lat;
        logic [127:0] exp;
        inv_mode = 1'b0;
        exp = {32'h046681e5, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};
        start_op({32'hd4bf5d30, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6});
        wait_done(lat);
        checks++;
        if (lat !== 4 || data_out !== exp) begin
            fails++;
            $display("FAIL mixed_columns: got %h latency %0d, required %h latency 4", data_out, lat, exp);
        end
        $display("txn mixed columns -> %h latency %0d", data_out, lat);
        finish_op();
    endtask

    task automatic test_random();
        int           lat;
        logic [127:0] din;
        logic [127:0] exp;
        inv_mode = 1'b0;
        for (int n = 0; n < 12; n++) begin
            din = rand128();
            exp = mix_model(din, 1'b0);
            start_op(din);
            wait_done(lat);
            checks++;
            if (lat !== 4 || data_out !== exp) begin
                fails++;
                $display("FAIL random_%0d: got %h latency %0d, required %h latency 4", n, data_out, lat, exp);
            end
            $display("txn random %0d in %h out %h", n, din, data_out);
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int           lat;
        logic [127:0] din;
        logic [127:0] exp;
        bit           bad;
        inv_mode = 1'b0;
        din = rand128();
        exp = mix_model(din, 1'b0);
        start_op(din);
        wait_done(lat);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            data_in  = rand128();
            @(posedge clk); #1;
            if (data_out !== exp || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (bad || lat !== 4) begin
            fails++;
            $display("FAIL backpressure_hold: got dout=%h vld=%b rdy=%b lat=%0d, required %h 1 0 4",
                     data_out, out_valid, in_ready, lat, exp);
        end
        $display("txn backpressure held 10 cycles out %h", data_out);
        finish_op();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_release: got rdy=%b vld=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int           lat;
        logic [127:0] d1;
        logic [127:0] d2;
        logic [127:0] exp;
        inv_mode = 1'b0;
        d1 = rand128();
        d2 = rand128();
        start_op(d1);
        wait_done(lat);
        // Offer the next state on the same edge that completes the handshake.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = d2;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_no_early_accept: got rdy=%b busy=%b, required 1 0", in_ready, busy);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in  = rand128();
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept: got busy=%b, required 1", busy);
        end
        exp = mix_model(d2, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== 4 || data_out !== exp) begin
            fails++;
            $display("FAIL b2b_result: got %h latency %0d, required %h latency 4", data_out, lat, exp);
        end
        $display("txn back-to-back in %h out %h", d2, data_out);
        finish_op();
    endtask

    task automatic test_clear();
        int           lat;
        logic [127:0] din;
        logic [127:0] exp;
        bit           saw_valid;
        inv_mode = 1'b0;
        start_op(rand128());
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL clear_to_idle: got rdy=%b busy=%b vld=%b, required 1 0 0", in_ready, busy, out_valid);
        end
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            fails++;
            $display("FAIL clear_no_result: got out_valid=1 after clear, required 0");
        end
        // clear outranks an acceptance offered in the same cycle
        clear    = 1'b1;
        in_valid = 1'b1;
        data_in  = rand128();
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL clear_priority: got busy=%b rdy=%b, required 0 1", busy, in_ready);
        end
        din = rand128();
        exp = mix_model(din, 1'b0);
        start_op(din);
        wait_done(lat);
        checks++;
        if (lat !== 4 || data_out !== exp) begin
            fails++;
            $display("FAIL clear_recovery: got %h latency %0d, required %h latency 4", data_out, lat, exp);
        end
        $display("txn after clear in %h out %h", din, data_out);
        finish_op();
    endtask

    task automatic test_async_reset();
        int           lat;
        logic [127:0] din;
        logic [127:0] exp;
        bit           saw_valid;
        inv_mode = 1'b0;
        start_op(rand128());
        @(posedge clk); #1;
        @(posedge clk); #2;
        n_rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || data_out !== 128'h0) begin
            fails++;
            $display("FAIL async_reset: got rdy=%b vld=%b busy=%b dout=%h, required 1 0 0 0",
                     in_ready, out_valid, busy, data_out);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            fails++;
            $display("FAIL async_reset_no_result: got activity after reset, required idle");
        end
        din = rand128();
        exp = mix_model(din, 1'b0);
        start_op(din);
        wait_done(lat);
        checks++;
        if (lat !== 4 || data_out !== exp) begin
            fails++;
            $display("FAIL reset_recovery: got %h latency %0d, required %h latency 4", data_out, lat, exp);
        end
        $display("txn after reset in %h out %h", din, data_out);
        finish_op();
    endtask

`ifdef MIX_COLUMNS_INV_EN
    task automatic test_inverse();
        int           lat;
        logic [127:0] din;
        logic [127:0] fwd;
        logic [127:0] exp;
        inv_mode = 1'b1;
        exp = {4{32'hdb135345}};
        start_op({4{32'h8e4da1bc}});
        wait_done(lat);
        checks++;
        if (lat !== 4 || data_out !== exp) begin
            fails++;
            $display("FAIL inverse_known: got %h latency %0d, required %h latency 4", data_out, lat, exp);
        end
        $display("txn inverse 8e4da1bc x4 -> %h", data_out);
        finish_op();
        for (int n = 0; n < 16; n++) begin
            din = rand128();
            inv_mode = 1'b0;
            start_op(din);
            inv_mode = 1'b1;
            wait_done(lat);
            fwd = data_out;
            checks++;
            if (lat !== 4 || fwd !== mix_model(din, 1'b0)) begin
                fails++;
                $display("FAIL roundtrip_fwd_%0d: got %h, required %h", n, fwd, mix_model(din, 1'b0));
            end
            finish_op();
            start_op(fwd);
            inv_mode = 1'b0;
            wait_done(lat);
            checks++;
            if (lat !== 4 || data_out !== din) begin
                fails++;
                $display("FAIL roundtrip_inv_%0d: got %h, required %h", n, data_out, din);
            end
            $display("txn roundtrip %0d in %h mid %h out %h", n, din, fwd, data_out);
            finish_op();
        end
        inv_mode = 1'b0;
    endtask
`endif

    initial begin
        checks    = 0;
        fails     = 0;
        inv_mode  = 1'b0;
        n_rst     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        test_reset();
        test_first_accept();
        test_mixed_columns();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_async_reset();
`ifdef MIX_COLUMNS_INV_EN
        test_inverse();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 SHALL have a parameter: none; all widths fixed (state 128 bits, column 32 bits).
REQ-002 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-003 SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port clear, input, 1 bit: synchronous abort of any operation in progress.
REQ-005 SHALL have port in_valid, input, 1 bit: data_in holds a state to process.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a state.
REQ-007 SHALL have port data_in, input, 128 bits: input state.
REQ-008 SHALL have port out_valid, output, 1 bit: data_out holds a result.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port data_out, output, 128 bits: mixed state.
REQ-011 SHALL have port busy, output, 1 bit: high in COMPUTE and DONE.

Function
REQ-012 SHALL map column c (0..3) to data bits [32c+31:32c], with byte b0 in [32c+31:32c+24] and b3 in [32c+7:32c].
REQ-013 SHALL compute the forward column as o0=2b0^3b1^b2^b3, o1=b0^2b1^3b2^b3, o2=b0^b1^2b2^3b3, o3=3b0^b1^b2^2b3.
REQ-014 SHALL compute GF(2^8) multiply by 2 as a left shift, XORed with 0x1B when b[7]=1; multiply by 3 SHALL equal mul2^b.
REQ-015 SHALL contain exactly one single-column mixer, time-shared across the four columns.
REQ-016 SHALL implement states IDLE, COMPUTE and DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE.
REQ-018 SHALL capture data_in into a 128-bit working register, set the column counter to 0 and enter COMPUTE when in_valid&&in_ready at a clock edge.
REQ-019 SHALL, in COMPUTE, write the mixer result of column cnt back in place on each edge and increment the 2-bit cnt.
REQ-020 SHALL go to DONE on the edge that writes column 3; the total latency SHALL be 4 edges from acceptance to out_valid=1.
REQ-021 SHALL drive out_valid=1 only in DONE, and SHALL hold data_out and out_valid stable until out_ready=1.
REQ-022 SHALL move DONE to IDLE when out_valid&&out_ready at an edge; a new input SHALL be accepted no earlier than the following edge.
REQ-023 SHALL drive data_out from the working register at all times; its contents SHALL be architecturally meaningful only while out_valid=1.
REQ-024 SHALL, on clear=1 in any state, enter IDLE on the next edge, zero cnt, and drop any accepted or pending result; clear SHALL take priority over the handshake.
REQ-025 SHALL ignore in_valid while busy=1, and changes to data_in outside acceptance SHALL have no effect.

Reset
REQ-026 SHALL, while n_rst=0, hold the state at IDLE, cnt=0 and the working register at 0, giving outputs in_ready=1, out_valid=0, busy=0 and data_out=0.
REQ-027 SHALL, on reset assertion mid-operation, abort immediately with no result produced.
REQ-028 SHALL allow the first acceptance on the first edge after n_rst deasserts.

Configuration
REQ-029 SHALL recognise the macro MIX_COLUMNS_INV_EN.
REQ-030 SHALL, when MIX_COLUMNS_INV_EN is defined, add an input port inv (1 bit), sampled at acceptance and held for the operation; inv=1 SHALL use the inverse matrix rows {0E,0B,0D,09} rotated per row.
REQ-031 SHALL, when MIX_COLUMNS_INV_EN is undefined, have no inv port, contain no inverse logic, and perform forward mixing only.

Verification
REQ-032 SHALL verify: all four columns = db135345 -> each output column = 8e4da1bc, with out_valid rising 4 edges after acceptance.
REQ-033 SHALL verify: columns (c3..c0) = d4bf5d30, f20a225c, 01010101, c6c6c6c6 -> 046681e5, 9fdc589d, 01010101, c6c6c6c6.
REQ-034 SHALL verify: out_ready=0 for 10 cycles in DONE -> data_out constant, in_ready=0, a second in_valid is ignored; out_ready=1 -> IDLE next edge.
REQ-035 SHALL verify: clear=1 on the second COMPUTE edge -> IDLE next edge, out_valid never asserted; the next input processes correctly.
REQ-036 SHALL verify: n_rst pulsed low mid-COMPUTE -> outputs immediately at reset values, with no result produced.
REQ-037 SHALL verify, with MIX_COLUMNS_INV_EN defined: inv=1 and columns 8e4da1bc -> db135345, and forward-then-inverse round-trips 16 random states.
